// File: rtl/udp_header_rx_mp.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | udp_header_rx_mp                                                         |
// | Strips the UDP header, matches the destination port against a table,     |
// | and gates the payload out as a registered byte stream.                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module udp_header_rx_mp #(
   parameter int NUM_PORTS = 4,
   parameter int MAX_LEN   = 1500,
   parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
   parameter int CNT_W     = $clog2(MAX_LEN + 1)
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [7:0]              data_in,
   input  logic                    data_valid,
   input  logic                    ip_header_done,
   input  logic [16*NUM_PORTS-1:0] port_table,
   input  logic [NUM_PORTS-1:0]    port_enable,
   output logic [7:0]              udp_data,
   output logic                    udp_data_valid,
   output logic                    udp_data_tlast,
   output logic [IDX_W-1:0]        udp_port_idx,
   output logic [15:0]             udp_src_port,
   output logic [15:0]             udp_payload_len,
   output logic                    udp_hdr_done,
   output logic                    err_len,
   output logic                    err_trunc,
   output logic                    drop_port
);

   typedef enum logic [2:0] {
      S_WAIT    = 3'd0,
      S_SRC     = 3'd1,
      S_DST     = 3'd2,
      S_LEN     = 3'd3,
      S_CSUM    = 3'd4,
      S_PAYLOAD = 3'd5,
      S_DROP    = 3'd6
   } state_t;

   state_t           r_state;
   logic             r_bcnt;
   logic [7:0]       r_hi;
   logic [15:0]      r_src;
   logic [IDX_W-1:0] r_idx;
   logic [CNT_W-1:0] r_plen;
   logic [CNT_W-1:0] r_pcnt;

   logic [15:0]      w_word;
   logic             w_hit;
   logic [IDX_W-1:0] w_idx;
   logic             w_len_ok;
   logic [CNT_W-1:0] w_plen;
   logic             w_last;

   assign w_word   = {r_hi, data_in};
   // Range check on the full 16-bit field before narrowing to the counter width
   assign w_len_ok = (w_word >= 16'd8) && (w_word <= 16'(MAX_LEN));
   assign w_plen   = CNT_W'(w_word - 16'd8);
   assign w_last   = (r_pcnt == (r_plen - CNT_W'(1)));

   // Scan from the top down so the lowest matching index is the one kept
   always_comb begin
      w_hit = 1'b0;
      w_idx = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (port_enable[i] && (port_table[16*i +: 16] == w_word)) begin
            w_hit = 1'b1;
            w_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state         <= S_WAIT;
         r_bcnt          <= 1'b0;
         r_hi            <= '0;
         r_src           <= '0;
         r_idx           <= '0;
         r_plen          <= '0;
         r_pcnt          <= '0;
         udp_data        <= '0;
         udp_data_valid  <= 1'b0;
         udp_data_tlast  <= 1'b0;
         udp_port_idx    <= '0;
         udp_src_port    <= '0;
         udp_payload_len <= '0;
         udp_hdr_done    <= 1'b0;
         err_len         <= 1'b0;
         err_trunc       <= 1'b0;
         drop_port       <= 1'b0;
      end else begin
         udp_data_valid <= 1'b0;
         udp_data_tlast <= 1'b0;
         udp_hdr_done   <= 1'b0;
         err_len        <= 1'b0;
         err_trunc      <= 1'b0;
         drop_port      <= 1'b0;

         case (r_state)
            S_WAIT: begin
               r_bcnt <= 1'b0;
               if (ip_header_done && data_valid) begin
                  r_state <= S_SRC;
               end
            end

            S_SRC, S_DST, S_LEN, S_CSUM: begin
               if (!data_valid) begin
                  err_trunc <= 1'b1;
                  r_bcnt    <= 1'b0;
                  r_state   <= S_WAIT;
               end else if (!r_bcnt) begin
                  r_hi   <= data_in;
                  r_bcnt <= 1'b1;
               end else begin
                  r_bcnt <= 1'b0;
                  case (r_state)
                     S_SRC: begin
                        r_src   <= w_word;
                        r_state <= S_DST;
                     end
                     S_DST: begin
                        if (w_hit) begin
                           r_idx   <= w_idx;
                           r_state <= S_LEN;
                        end else begin
                           drop_port <= 1'b1;
                           r_state   <= S_DROP;
                        end
                     end
                     S_LEN: begin
                        if (w_len_ok) begin
                           r_plen  <= w_plen;
                           r_state <= S_CSUM;
                        end else begin
                           err_len <= 1'b1;
                           r_state <= S_DROP;
                        end
                     end
                     default: begin
                        udp_hdr_done    <= 1'b1;
                        udp_port_idx    <= r_idx;
                        udp_src_port    <= r_src;
                        udp_payload_len <= 16'(r_plen);
                        r_pcnt          <= '0;
                        if (r_plen == '0) begin
                           r_state <= S_WAIT;
                        end else begin
                           r_state <= S_PAYLOAD;
                        end
                     end
                  endcase
               end
            end

            S_PAYLOAD: begin
               if (!data_valid) begin
                  err_trunc <= 1'b1;
                  r_state   <= S_WAIT;
               end else begin
                  udp_data       <= data_in;
                  udp_data_valid <= 1'b1;
                  if (w_last) begin
                     udp_data_tlast <= 1'b1;
                     r_state        <= S_WAIT;
                  end else begin
                     r_pcnt <= r_pcnt + CNT_W'(1);
                  end
               end
            end

            S_DROP: begin
               if (!data_valid) begin
                  r_state <= S_WAIT;
               end
            end

            default: begin
               r_state <= S_WAIT;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_udp_header_rx_mp.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_udp_header_rx_mp                                                      |
// | Self-checking bench: vector table, hand sequences, randomized frames.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_udp_header_rx_mp;

   localparam int NP = 4;
   localparam int ML = 1500;
   localparam int IW = 2;

   logic              aclk = 1'b0;
   logic              aresetn = 1'b0;
   logic [7:0]        data_in = '0;
   logic              data_valid = 1'b0;
   logic              ip_header_done = 1'b0;
   logic [16*NP-1:0]  port_table;
   logic [NP-1:0]     port_enable;
   logic [7:0]        udp_data;
   logic              udp_data_valid;
   logic              udp_data_tlast;
   logic [IW-1:0]     udp_port_idx;
   logic [15:0]       udp_src_port;
   logic [15:0]       udp_payload_len;
   logic              udp_hdr_done;
   logic              err_len;
   logic              err_trunc;
   logic              drop_port;

   udp_header_rx_mp #(.NUM_PORTS(NP), .MAX_LEN(ML)) dut (
      .aclk(aclk), .aresetn(aresetn), .data_in(data_in), .data_valid(data_valid),
      .ip_header_done(ip_header_done), .port_table(port_table), .port_enable(port_enable),
      .udp_data(udp_data), .udp_data_valid(udp_data_valid), .udp_data_tlast(udp_data_tlast),
      .udp_port_idx(udp_port_idx), .udp_src_port(udp_src_port),
      .udp_payload_len(udp_payload_len), .udp_hdr_done(udp_hdr_done),
      .err_len(err_len), .err_trunc(err_trunc), .drop_port(drop_port)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [15:0] dst;
      int          len;
      int          n;
      bit          hdr;
      int          idx;
      int          plen;
      int          nbytes;
      bit          tlast;
      bit          drop;
      bit          elen;
      bit          trunc;
   } vec_t;

   int checks = 0;
   int failures = 0;

   int         n_hdr, n_drop, n_elen, n_trunc, n_tlast, tlast_pos;
   int         m_idx, m_src, m_plen;
   logic [7:0] got_q[$];
   logic [7:0] last_in;
   logic [7:0] frm[$];
   logic [7:0] sav[$];

   task automatic chk(input string nm, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
      end
   endtask

   function automatic longint all_outs();
      return {udp_data, udp_data_valid, udp_data_tlast, udp_port_idx, udp_src_port,
              udp_payload_len, udp_hdr_done, err_len, err_trunc, drop_port};
   endfunction

   always @(posedge aclk) last_in = data_in;

   always @(negedge aclk) begin
      if (udp_data_valid) begin
         got_q.push_back(udp_data);
         chk("payload_latency", udp_data, last_in);
      end
      if (udp_data_tlast) begin
         n_tlast++;
         tlast_pos = got_q.size() - 1;
      end
      if (udp_hdr_done) begin
         n_hdr++;
         m_idx  = int'(udp_port_idx);
         m_src  = int'(udp_src_port);
         m_plen = int'(udp_payload_len);
      end
      if (drop_port) n_drop++;
      if (err_len)   n_elen++;
      if (err_trunc) n_trunc++;
   end

   task automatic clear_mon();
      n_hdr = 0; n_drop = 0; n_elen = 0; n_trunc = 0; n_tlast = 0; tlast_pos = -1;
      m_idx = -1; m_src = -1; m_plen = -1;
      got_q.delete();
   endtask

   // Reference: walk the datagram field by field and decide what the block reports
   function automatic vec_t model(input logic [15:0] dst, input int len, input int n);
      vec_t e;
      int   hit;
      e = '{dst: dst, len: len, n: n, hdr: 0, idx: 0, plen: 0, nbytes: 0,
            tlast: 0, drop: 0, elen: 0, trunc: 0};
      if (n < 4) begin e.trunc = 1; return e; end
      hit = -1;
      for (int i = 0; i < NP; i++)
         if (hit < 0 && port_enable[i] && port_table[16*i +: 16] == dst) hit = i;
      if (hit < 0) begin e.drop = 1; return e; end
      if (n < 6) begin e.trunc = 1; return e; end
      if (len < 8 || len > ML) begin e.elen = 1; return e; end
      if (n < 8) begin e.trunc = 1; return e; end
      e.hdr  = 1;
      e.idx  = hit;
      e.plen = len - 8;
      if (e.plen == 0) return e;
      e.nbytes = (n - 8 < e.plen) ? n - 8 : e.plen;
      e.tlast  = (n - 8 >= e.plen);
      e.trunc  = !e.tlast;
      return e;
   endfunction

   task automatic build_frame(input logic [15:0] src, input logic [15:0] dst,
                              input int len, input int n);
      logic [15:0] l16;
      logic [7:0]  hdr8 [8];
      l16 = 16'(len);
      hdr8[0] = src[15:8]; hdr8[1] = src[7:0];
      hdr8[2] = dst[15:8]; hdr8[3] = dst[7:0];
      hdr8[4] = l16[15:8]; hdr8[5] = l16[7:0];
      hdr8[6] = 8'($urandom); hdr8[7] = 8'($urandom);
      frm.delete();
      for (int i = 0; i < n; i++) frm.push_back((i < 8) ? hdr8[i] : 8'($urandom));
   endtask

   task automatic drive_start();
      @(posedge aclk); #1;
      data_valid = 1'b1;
      ip_header_done = 1'b1;
      data_in = 8'($urandom);
   endtask

   task automatic drive_bytes(input int from, input int to);
      for (int i = from; i <= to; i++) begin
         @(posedge aclk); #1;
         ip_header_done = 1'b0;
         data_in = frm[i];
      end
   endtask

   task automatic end_frame(input int gap);
      @(posedge aclk); #1;
      data_valid = 1'b0;
      ip_header_done = 1'b0;
      data_in = '0;
      repeat (gap) @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic [15:0] src, input vec_t v);
      build_frame(src, v.dst, v.len, v.n);
      clear_mon();
      drive_start();
      if (v.n > 0) drive_bytes(0, v.n - 1);
      end_frame(3);
   endtask

   task automatic check_frame(input string tag, input vec_t e, input logic [15:0] src);
      chk({tag, " hdr_done"}, n_hdr, e.hdr);
      chk({tag, " drop_port"}, n_drop, e.drop);
      chk({tag, " err_len"}, n_elen, e.elen);
      chk({tag, " err_trunc"}, n_trunc, e.trunc);
      chk({tag, " tlast_count"}, n_tlast, e.tlast);
      chk({tag, " byte_count"}, got_q.size(), e.nbytes);
      if (e.hdr) begin
         chk({tag, " port_idx"}, m_idx, e.idx);
         chk({tag, " src_port"}, m_src, src);
         chk({tag, " payload_len"}, m_plen, e.plen);
      end
      if (e.tlast) chk({tag, " tlast_pos"}, tlast_pos, e.nbytes - 1);
      for (int i = 0; i < got_q.size() && i < e.nbytes; i++)
         chk({tag, " payload_byte"}, got_q[i], frm[8 + i]);
   endtask

   task automatic std_table();
      port_table  = {16'h0000, 16'h1234, 16'h0050, 16'h1234};
      port_enable = 4'b0111;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[12];
      vec_t        e;
      logic [15:0] src;
      logic [15:0] dst;
      int          len, n, sel;
      logic [15:0] pool [4];

      std_table();
      clear_mon();
      repeat (3) @(posedge aclk);
      #1;
      chk("reset_outputs", all_outs(), 0);
      aresetn = 1'b1;

      tbl[0]  = '{dst:16'h1234, len:12,   n:12,   hdr:1, idx:0, plen:4,    nbytes:4,    tlast:1, drop:0, elen:0, trunc:0};
      tbl[1]  = '{dst:16'h0000, len:12,   n:12,   hdr:0, idx:0, plen:0,    nbytes:0,    tlast:0, drop:1, elen:0, trunc:0};
      tbl[2]  = '{dst:16'h0050, len:12,   n:12,   hdr:1, idx:1, plen:4,    nbytes:4,    tlast:1, drop:0, elen:0, trunc:0};
      tbl[3]  = '{dst:16'h1234, len:6,    n:14,   hdr:0, idx:0, plen:0,    nbytes:0,    tlast:0, drop:0, elen:1, trunc:0};
      tbl[4]  = '{dst:16'h1234, len:1501, n:20,   hdr:0, idx:0, plen:0,    nbytes:0,    tlast:0, drop:0, elen:1, trunc:0};
      tbl[5]  = '{dst:16'h1234, len:8,    n:8,    hdr:1, idx:0, plen:0,    nbytes:0,    tlast:0, drop:0, elen:0, trunc:0};
      tbl[6]  = '{dst:16'h0050, len:30,   n:48,   hdr:1, idx:1, plen:22,   nbytes:22,   tlast:1, drop:0, elen:0, trunc:0};
      tbl[7]  = '{dst:16'h1234, len:20,   n:13,   hdr:1, idx:0, plen:12,   nbytes:5,    tlast:0, drop:0, elen:0, trunc:1};
      tbl[8]  = '{dst:16'h1234, len:12,   n:5,    hdr:0, idx:0, plen:0,    nbytes:0,    tlast:0, drop:0, elen:0, trunc:1};
      tbl[9]  = '{dst:16'h9999, len:12,   n:12,   hdr:0, idx:0, plen:0,    nbytes:0,    tlast:0, drop:1, elen:0, trunc:0};
      tbl[10] = '{dst:16'h0050, len:1500, n:1500, hdr:1, idx:1, plen:1492, nbytes:1492, tlast:1, drop:0, elen:0, trunc:0};
      tbl[11] = '{dst:16'h1234, len:9,    n:9,    hdr:1, idx:0, plen:1,    nbytes:1,    tlast:1, drop:0, elen:0, trunc:0};

      for (int k = 0; k < 12; k++) begin
         src = 16'h4000 + 16'(k);
         build_frame(src, tbl[k].dst, tbl[k].len, tbl[k].n);
         if (k == 0) begin
            frm[8] = 8'hDE; frm[9] = 8'hAD; frm[10] = 8'hBE; frm[11] = 8'hEF;
         end
         clear_mon();
         drive_start();
         drive_bytes(0, tbl[k].n - 1);
         end_frame(3);
         check_frame($sformatf("vec%0d", k), tbl[k], src);
      end

      // Truncated payload immediately followed by a good frame (one idle cycle)
      clear_mon();
      build_frame(16'h1111, 16'h1234, 20, 13);
      sav = frm;
      drive_start();
      drive_bytes(0, 12);
      end_frame(0);
      build_frame(16'h2222, 16'h0050, 12, 12);
      drive_start();
      drive_bytes(0, 11);
      end_frame(3);
      chk("b2b hdr_done", n_hdr, 2);
      chk("b2b err_trunc", n_trunc, 1);
      chk("b2b tlast_count", n_tlast, 1);
      chk("b2b byte_count", got_q.size(), 9);
      chk("b2b tlast_pos", tlast_pos, 8);
      chk("b2b port_idx", m_idx, 1);
      chk("b2b src_port", m_src, 16'h2222);
      chk("b2b payload_len", m_plen, 4);
      for (int i = 0; i < got_q.size() && i < 9; i++)
         chk("b2b payload_byte", got_q[i], (i < 5) ? sav[8 + i] : frm[8 + i - 5]);

      // Asynchronous reset in the middle of a payload
      clear_mon();
      build_frame(16'h3333, 16'h0050, 20, 20);
      drive_start();
      drive_bytes(0, 10);
      @(posedge aclk); #2;
      chk("rst_pre_valid", udp_data_valid, 1);
      aresetn = 1'b0;
      data_valid = 1'b0;
      #1;
      chk("rst_async_outputs", all_outs(), 0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      e = model(16'h1234, 12, 12);
      send(16'h5555, e);
      check_frame("post_rst", e, 16'h5555);

      pool[0] = 16'h0050; pool[1] = 16'h1234; pool[2] = 16'h0035; pool[3] = 16'h0000;
      for (int r = 0; r < 80; r++) begin
         for (int i = 0; i < NP; i++)
            port_table[16*i +: 16] = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)]
                                                                  : 16'($urandom);
         port_enable = 4'($urandom);
         sel = $urandom_range(0, 9);
         dst = (sel < 7) ? port_table[16*$urandom_range(0, NP-1) +: 16] : 16'($urandom);
         sel = $urandom_range(0, 9);
         if (sel == 0)      len = $urandom_range(0, 7);
         else if (sel == 1) len = ML + 1 + $urandom_range(0, 100);
         else if (sel == 2) len = 8;
         else               len = $urandom_range(9, 60);
         if (len < 8 || len > ML) n = $urandom_range(1, 20);
         else if ($urandom_range(0, 1) == 1) n = len + $urandom_range(0, 6);
         else n = $urandom_range(1, len + 6);
         src = 16'($urandom);
         e = model(dst, len, n);
         send(src, e);
         check_frame($sformatf("rnd%0d", r), e, src);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/udp_header_rx_mp.md
Name: udp_header_rx_mp

Overview:
Multi-port UDP header parser and payload gate. It sits after the IPv4 header parser on the byte-wide RX path. It strips the 8-byte UDP header and compares the destination port against a table of NUM_PORTS programmable ports. For a match, it forwards the payload as a registered byte stream with valid/last framing, the matched port index and header metadata. It also flags length errors, truncated frames and unmatched ports.

Parameters:
NUM_PORTS, 4, number of destination-port table entries (1..16)
MAX_LEN, 1500, largest accepted UDP Length field in bytes (header included)
IDX_W, $clog2(NUM_PORTS) (min 1), width of the port index output
CNT_W, $clog2(MAX_LEN+1), width of the byte counter

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  asynchronous active-low reset
data_in  in  8  RX byte stream
data_valid  in  1  byte qualifier; high continuously for the whole frame, low between frames
ip_header_done  in  1  high for one cycle with the last IPv4 header byte; the first UDP byte arrives on the next data_valid cycle
port_table  in  16*NUM_PORTS  destination ports; entry i = port_table[16*i +: 16]; must be quasi-static
port_enable  in  NUM_PORTS  per-entry enable
udp_data  out  8  payload byte, registered
udp_data_valid  out  1  payload byte qualifier
udp_data_tlast  out  1  high with the last payload byte
udp_port_idx  out  IDX_W  matched entry; stable from hdr_done until the next frame's hdr_done
udp_src_port  out  16  source port of the current/last accepted datagram
udp_payload_len  out  16  Length field minus 8
udp_hdr_done  out  1  one-cycle pulse when an accepted header completes
err_len  out  1  one-cycle pulse: Length < 8 or Length > MAX_LEN
err_trunc  out  1  one-cycle pulse: data_valid dropped before the payload ended
drop_port  out  1  one-cycle pulse: no enabled entry matched

Behaviour:
- Reset state: every output is 0; the FSM is in WAIT; all counters are 0.
- States are WAIT, SRC, DST, LEN, CSUM, PAYLOAD and DROP.
- All header states consume 2 bytes, MSB first. An internal 1-bit byte counter advances only on data_valid.
- WAIT: go to SRC on ip_header_done && data_valid. Otherwise stay.
- SRC: capture the source port, then go to DST.
- DST: on the 2nd byte, compare {hi,lo} against every entry whose port_enable bit is set.
  - Lowest-index match wins; latch its index internally.
  - No match: pulse drop_port and go to DROP.
  - Match: go to LEN.
- LEN: on the 2nd byte, evaluate L = {hi,lo}.
  - L < 8 or L > MAX_LEN: pulse err_len and go to DROP.
  - Otherwise: latch payload_len = L-8 and go to CSUM.
- CSUM: consume 2 bytes; the checksum is ignored. On the 2nd byte, drive the header outputs:
  - Pulse udp_hdr_done.
  - Update udp_port_idx, udp_src_port and udp_payload_len.
  - payload_len == 0: set udp_data_valid = 0 and return to WAIT.
  - Otherwise: go to PAYLOAD.
- PAYLOAD: each data_valid byte is registered to udp_data with udp_data_valid = 1, so output latency is 1 cycle.
  - The payload counter runs 0..payload_len-1.
  - udp_data_tlast = 1 on the byte where count == payload_len-1; then go to WAIT.
  - Trailing bytes after the payload (Ethernet padding) are ignored in WAIT.
- DROP: ignore bytes until data_valid = 0, then go to WAIT.
- Abort: data_valid = 0 in any state other than WAIT or DROP returns the FSM to WAIT next cycle.
  - If the abort happens in PAYLOAD, pulse err_trunc and drive udp_data_valid = 0 next cycle.
  - No tlast is emitted for an aborted payload.
  - If the abort happens in SRC..CSUM, pulse err_trunc and suppress udp_hdr_done.
- ip_header_done while not in WAIT is ignored.
- Comparisons use full 16-bit values.
- Counter arithmetic is CNT_W wide; L is checked against MAX_LEN before narrowing.
- Mid-operation reset: all outputs drop to 0 asynchronously; the FSM returns to WAIT.

Test Plan:
- Table {0x1234, 0x0050, 0x1234, 0x0000} with enable 4'b0111; datagram to port 0x1234, L = 12, payload DE AD BE EF -> udp_hdr_done, udp_port_idx = 0, udp_payload_len = 4, bytes DE AD BE EF on 4 consecutive cycles one cycle after input, tlast on EF.
- Datagram to port 0x0000 (entry 3 disabled) -> drop_port pulse, no udp_data_valid, FSM back in WAIT after data_valid falls; a next datagram to 0x0050 is accepted with idx = 1.
- L = 6, then a separate frame with L = MAX_LEN+1 -> err_len pulse each time, no payload output.
- L = 8 -> udp_hdr_done, udp_payload_len = 0, no udp_data_valid; L = 30 followed by 18 padding bytes -> exactly 22 payload bytes, tlast on the 22nd, padding ignored.
- L = 20 with data_valid dropped after 5 payload bytes -> 5 valid bytes, err_trunc pulse, no tlast; a back-to-back frame parses correctly.
- Assert aresetn low during PAYLOAD -> all outputs 0 immediately; after release the next frame parses normally.
